// File: rtl/win_screen_drawer_if.sv
// Signal bundle between the VGA timing/background side, the banner ROM and the win-screen compositor.
interface win_screen_drawer_if;
  logic        win_trigger;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [23:0] bg_rgb;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pixel_rgb;
  logic        active;
  logic        done;

  modport master (
    output win_trigger, frame_start, DrawX, DrawY, bg_rgb, rom_data,
    input  rom_addr, pixel_rgb, active, done
  );

  modport slave (
    input  win_trigger, frame_start, DrawX, DrawY, bg_rgb, rom_data,
    output rom_addr, pixel_rgb, active, done
  );
endinterface

// File: rtl/win_screen_drawer.sv
// Win-banner compositor: generates sprite ROM addresses from the scan position, overlays ROM pixels
// on the background and reveals the banner top-down one step per frame before holding and finishing.
module win_screen_drawer #(
  parameter int IMG_W       = 169,
  parameter int IMG_H       = 150,
  parameter int POS_X       = 235,
  parameter int POS_Y       = 165,
  parameter int REVEAL_STEP = 2,
  parameter int HOLD_FRAMES = 180
) (
  input logic               Clk,
  input logic               Reset,
  win_screen_drawer_if.slave bus
);

  localparam logic [9:0] X_LO      = 10'(POS_X);
  localparam logic [9:0] X_HI      = 10'(POS_X + IMG_W - 1);
  localparam logic [9:0] Y_LO      = 10'(POS_Y);
  localparam logic [9:0] Y_HI      = 10'(POS_Y + IMG_H - 1);
  localparam logic [8:0] STEP9     = 9'(REVEAL_STEP);
  localparam logic [8:0] H9        = 9'(IMG_H);
  localparam logic [7:0] H8        = 8'(IMG_H);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, REVEAL, HOLD, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  reveal_rows, rows_next;
  logic [7:0]  hold_cnt, hold_next;
  logic [8:0]  rows_sum;

  logic [9:0]  rel_x, rel_y;
  logic        in_win;
  logic [14:0] addr_calc;

  logic [14:0] rom_addr_q;
  logic        in_win_d1, in_win_d2;
  logic [23:0] bg_d1, bg_d2;
  logic [23:0] pixel_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      reveal_rows <= 8'd0;
      hold_cnt    <= 8'd0;
    end else begin
      state       <= state_next;
      reveal_rows <= rows_next;
      hold_cnt    <= hold_next;
    end
  end

  // A trigger in IDLE/DONE takes priority over a coincident frame_start, so the reveal restarts at row 0.
  always_comb begin
    state_next = state;
    rows_next  = reveal_rows;
    hold_next  = hold_cnt;
    rows_sum   = {1'b0, reveal_rows} + STEP9;
    case (state)
      IDLE: begin
        if (bus.win_trigger) begin
          state_next = REVEAL;
          rows_next  = 8'd0;
          hold_next  = 8'd0;
        end
      end
      REVEAL: begin
        if (bus.frame_start) begin
          if (rows_sum >= H9) begin
            rows_next  = H8;
            state_next = HOLD;
          end else begin
            rows_next  = rows_sum[7:0];
          end
        end
      end
      HOLD: begin
        if (bus.frame_start) begin
          hold_next = hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.win_trigger) begin
          state_next = REVEAL;
          rows_next  = 8'd0;
          hold_next  = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rel_x = bus.DrawX - X_LO;
  assign rel_y = bus.DrawY - Y_LO;

  assign in_win = (bus.DrawX >= X_LO) && (bus.DrawX <= X_HI) &&
                  (bus.DrawY >= Y_LO) && (bus.DrawY <= Y_HI) &&
                  (rel_y < {2'b00, reveal_rows}) && (state != IDLE);

  // In-window offsets keep the product below 25350, so 15 bits hold it without wrap.
  assign addr_calc = 15'(rel_y) * 15'(IMG_W) + 15'(rel_x);

  // Flag and background ride two stages so they line up with the ROM word fetched for the same pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= 15'd0;
      in_win_d1  <= 1'b0;
      in_win_d2  <= 1'b0;
      bg_d1      <= 24'd0;
      bg_d2      <= 24'd0;
      pixel_q    <= 24'd0;
    end else begin
      rom_addr_q <= in_win ? addr_calc : 15'd0;
      in_win_d1  <= in_win;
      in_win_d2  <= in_win_d1;
      bg_d1      <= bus.bg_rgb;
      bg_d2      <= bg_d1;
      pixel_q    <= in_win_d2 ? bus.rom_data : bg_d2;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pixel_rgb = pixel_q;
  assign bus.active    = (state == REVEAL) || (state == HOLD);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_win_screen_drawer.sv
// Directed bench for win_screen_drawer: reveal sequence, address mapping, pipeline alignment and reset.
module tb_win_screen_drawer;

  localparam logic [23:0] ROM_VAL = 24'h5A5A5A;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  win_screen_drawer_if bus();

  win_screen_drawer dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y, input logic [23:0] bg);
    bus.DrawX  = x;
    bus.DrawY  = y;
    bus.bg_rgb = bg;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_trigger();
    bus.win_trigger = 1'b1;
    tick();
    bus.win_trigger = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) pulse_frame();
  endtask

  // Hold one scan position for three edges: address after the first, composited pixel after the third.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [14:0] exp_addr, input logic exp_in);
    logic [23:0] bg;
    bg = {2'b01, x, 2'b10, y};
    bus.rom_data = ROM_VAL;
    apply_stimulus(x, y, bg);
    tick();
    check_output({tag, "_addr"}, 24'(bus.rom_addr), 24'(exp_addr));
    tick();
    tick();
    check_output({tag, "_pix"}, bus.pixel_rgb, exp_in ? ROM_VAL : bg);
  endtask

  initial begin
    logic [23:0] bg_hist [64];
    logic [9:0]  sx, sy;

    bus.win_trigger = 1'b0;
    bus.frame_start = 1'b0;
    bus.rom_data    = ROM_VAL;
    apply_stimulus(10'd0, 10'd0, 24'd0);
    tick();
    tick();
    reset = 1'b0;

    check_output("rst_addr",   24'(bus.rom_addr), 24'd0);
    check_output("rst_pix",    bus.pixel_rgb,     24'd0);
    check_output("rst_active", 24'(bus.active),   24'd0);
    check_output("rst_done",   24'(bus.done),     24'd0);

    // Idle sweep: nothing is drawn even where the banner would sit.
    for (int i = 0; i < 64; i++) begin
      sx = 10'((i * 37) % 640);
      sy = 10'((i * 53) % 480);
      if (i % 8 == 3) begin
        sx = 10'(235 + i);
        sy = 10'(165 + i);
      end
      bg_hist[i] = {2'b11, sx, 2'b00, sy};
      apply_stimulus(sx, sy, bg_hist[i]);
      tick();
      check_output("sweep_addr", 24'(bus.rom_addr), 24'd0);
      if (i >= 2) check_output("sweep_pix", bus.pixel_rgb, bg_hist[i-2]);
    end
    check_output("sweep_done", 24'(bus.done), 24'd0);

    // One reveal step exposes rows 165 and 166 only.
    pulse_trigger();
    check_output("trig_active", 24'(bus.active), 24'd1);
    pulse_frame();
    probe("r2_tl",   10'd235, 10'd165, 15'd0,   1'b1);
    probe("r2_edge", 10'd403, 10'd166, 15'd337, 1'b1);
    probe("r2_out",  10'd235, 10'd167, 15'd0,   1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_trigger();
    frames(74);
    probe("r148_last", 10'd403, 10'd312, 15'd25011, 1'b1);
    probe("r148_next", 10'd403, 10'd313, 15'd0,     1'b0);
    check_output("r148_active", 24'(bus.active), 24'd1);
    pulse_frame();
    probe("full_br",   10'd403, 10'd314, 15'd25349, 1'b1);
    probe("full_right",10'd404, 10'd314, 15'd0,     1'b0);
    probe("full_left", 10'd234, 10'd165, 15'd0,     1'b0);
    check_output("hold_active", 24'(bus.active), 24'd1);
    check_output("hold_done",   24'(bus.done),   24'd0);

    frames(179);
    check_output("hold179_done",   24'(bus.done),   24'd0);
    check_output("hold179_active", 24'(bus.active), 24'd1);
    pulse_frame();
    check_output("done_done",   24'(bus.done),   24'd1);
    check_output("done_active", 24'(bus.active), 24'd0);
    probe("done_br", 10'd403, 10'd314, 15'd25349, 1'b1);

    pulse_trigger();
    check_output("retrig_active", 24'(bus.active), 24'd1);
    check_output("retrig_done",   24'(bus.done),   24'd0);
    probe("retrig_tl", 10'd235, 10'd165, 15'd0, 1'b0);

    // 18 steps reveal rows up to y=200; ROM word presented only two cycles after the in-window address.
    frames(18);
    bus.rom_data = 24'h000000;
    apply_stimulus(10'd234, 10'd200, 24'h111111);
    tick();
    apply_stimulus(10'd235, 10'd200, 24'h222222);
    tick();
    check_output("align_addr", 24'(bus.rom_addr), 24'd5915);
    apply_stimulus(10'd404, 10'd200, 24'h333333);
    tick();
    check_output("align_pre", bus.pixel_rgb, 24'h111111);
    apply_stimulus(10'd234, 10'd200, 24'h444444);
    bus.rom_data = 24'h262828;
    tick();
    check_output("align_hit", bus.pixel_rgb, 24'h262828);
    bus.rom_data = 24'h000000;
    apply_stimulus(10'd234, 10'd200, 24'h555555);
    tick();
    check_output("align_post", bus.pixel_rgb, 24'h333333);

    probe("pre_rst", 10'd403, 10'd166, 15'd337, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_output("async_addr",   24'(bus.rom_addr), 24'd0);
    check_output("async_pix",    bus.pixel_rgb,     24'd0);
    check_output("async_active", 24'(bus.active),   24'd0);
    check_output("async_done",   24'(bus.done),     24'd0);
    tick();
    reset = 1'b0;

    // Trigger and frame_start together: the trigger wins and no rows are revealed yet.
    bus.win_trigger = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.win_trigger = 1'b0;
    bus.frame_start = 1'b0;
    check_output("both_active", 24'(bus.active), 24'd1);
    probe("both_r0", 10'd235, 10'd165, 15'd0, 1'b0);
    pulse_frame();
    probe("both_r1", 10'd235, 10'd166, 15'd169, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
